score_disp_mux: RTL and testbench
=================================

SCORE_DISP_MUX -- requirements
Module: score_disp_mux

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 The module SHALL have parameter SCAN_HZ, default 1000, meaning the digit scan rate in Hz; DIV = CLK_HZ/SCAN_HZ, DIV >= 2.
REQ-003 The module SHALL have parameter SCORE_W, default 4, meaning the score width in bits per player.
REQ-004 The module SHALL have parameter DIGS, default 2, meaning the decimal digits per player; NDIG = 2*DIGS.
REQ-005 The module SHALL have port clk, input, 1 bit, the single system clock.
REQ-006 The module SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The module SHALL have port score1, input, SCORE_W bits, the player-1 binary score.
REQ-008 The module SHALL have port score2, input, SCORE_W bits, the player-2 binary score.
REQ-009 The module SHALL have port blink, input, 2 bits; bit0 selects player 1 and bit1 selects player 2 (used only with the macro in REQ-026).
REQ-010 The module SHALL have port seg, output, 7 bits, active-low segments ordered {g,f,e,d,c,b,a}.
REQ-011 The module SHALL have port sel, output, NDIG bits, active-low one-hot digit select; digit 0 is player-1 LSD and digit NDIG-1 is player-2 MSD.
REQ-012 The module SHALL have port frame, output, 1 bit, a one-cycle pulse when the scan wraps to digit 0.

Function
REQ-013 The prescaler SHALL count 0..DIV-1 and wrap, asserting an internal tick for exactly one cycle when the count equals DIV-1.
REQ-014 On each tick, the digit index SHALL advance by 1, wrapping from NDIG-1 to 0.
REQ-015 The frame output SHALL pulse for one cycle on the tick on which the index wraps to 0.
REQ-016 Both scores SHALL be latched into shadow registers on the cycle frame pulses; input changes mid-frame SHALL NOT alter the current frame.
REQ-017 The latched scores SHALL be converted to DIGS BCD digits per player by the cycle after the latch.
REQ-018 If a latched score is at least 10^DIGS, the display SHALL saturate to all 9s.
REQ-019 Leading zeros SHALL be blanked (seg = 7'h7F), except the LSD of each player, which always shows; a score of 0 displays a single "0".
REQ-020 seg and sel SHALL be registered and change together, one cycle after the tick.
REQ-021 The decoder SHALL map 0-9 to standard patterns; for example, "0" is 7'b1000000 and "1" is 7'b1111001.
REQ-022 Exactly one sel bit SHALL be low at all times outside reset.

Reset
REQ-023 While rst is low, the prescaler, index and shadow scores SHALL be 0, sel SHALL be all ones, seg SHALL be 7'h7F, and frame SHALL be 0.
REQ-024 Asserting reset mid-frame SHALL take effect immediately (asynchronous) and abort the scan.
REQ-025 After release, the first tick SHALL drive digit 1 (the index advances from 0), and the first frame pulse SHALL occur after NDIG ticks.

Configuration
REQ-026 With SCORE_BLINK_EN defined, a 2 Hz toggle (period CLK_HZ/2 cycles, counted in ticks and reset to the "on" phase) SHALL blank all digits of every player whose blink bit is high during the "off" phase.
REQ-027 Without SCORE_BLINK_EN, the blink input SHALL be ignored, no blink counter logic SHALL exist, and the display SHALL always be on.

Verification (CLK_HZ=100, SCAN_HZ=10, DIV=10, SCORE_W=7, DIGS=2)
REQ-028 Scenario: reset, then score1=5, score2=12 -> sel cycles 1110,1101,1011,0111 every 10 clocks; seg sequence is 7'b0010010 (5), blank, 7'b0100100 (2), 7'b1111001 (1).
REQ-029 Scenario: score1=0 -> digit 0 shows 7'b1000000 and digit 1 is 7'h7F.
REQ-030 Scenario: score2=120 -> digits 2 and 3 both show 7'b0010000 (9).
REQ-031 Scenario: change score1 from 3 to 7 at digit index 2 -> the current frame still shows 3, and 7 appears from the next frame.
REQ-032 Scenario: pull rst low for 3 clocks mid-scan -> sel=1111 and seg=7'h7F immediately; after release the scan restarts and the first frame pulse comes 40 clocks later.
REQ-033 Scenario (SCORE_BLINK_EN, blink=2'b01) -> player-1 digits blank during alternate 50-clock phases; player-2 digits are unaffected.

Source files
------------

// File: rtl/score_disp_mux.sv
// ---------------------------------------------------------------------------
// score_disp_mux
//   Time-multiplexed driver for a two-player score display built from
//   2*DIGS common-anode seven-segment digits. A prescaler produces a scan
//   tick at SCAN_HZ, and each tick advances the active digit. Both scores
//   are sampled into shadow registers once per frame, so a frame never
//   shows a torn value. The latched scores are then shown in decimal with
//   leading zeros blanked and saturation at all 9s.
//
//   Optional feature: define SCORE_BLINK_EN to blank a player's digits
//   during the "off" half of a 2 Hz blink. The default build has no blink
//   logic and ignores the blink input.
//
// Ports
//   clk     in   system clock (CLK_HZ)
//   rst     in   asynchronous reset, active low
//   score1  in   player-1 binary score, SCORE_W bits
//   score2  in   player-2 binary score, SCORE_W bits
//   blink   in   bit0 blinks player 1, bit1 blinks player 2 (SCORE_BLINK_EN)
//   seg     out  active-low segments {g,f,e,d,c,b,a}
//   sel     out  active-low one-hot digit select; bit 0 = player-1 LSD,
//                bit 2*DIGS-1 = player-2 MSD
//   frame   out  one-cycle pulse on the tick where the scan wraps to digit 0
// ---------------------------------------------------------------------------
module score_disp_mux #(
    parameter int CLK_HZ  = 50000000,
    parameter int SCAN_HZ = 1000,
    parameter int SCORE_W = 4,
    parameter int DIGS    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score1,
    input  logic [SCORE_W-1:0] score2,
    input  logic [1:0]         blink,
    output logic [6:0]         seg,
    output logic [2*DIGS-1:0]  sel,
    output logic               frame
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int NDIG  = 2 * DIGS;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NDIG);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int unsigned pow10(input int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int unsigned SAT_LIMIT = pow10(DIGS);

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Segment pattern of decimal position k of value v. k is a constant in
    // every call site, so the divide and modulo reduce to constant logic.
    function automatic logic [6:0] digit_pat(input logic [SCORE_W-1:0] v, input int k);
        int unsigned val = 32'(v);
        if (val >= SAT_LIMIT) return seg_of(4'd9);
        // Leading zero: no significant digit at or above this position.
        if (k > 0 && val < pow10(k)) return SEG_BLANK;
        return seg_of(4'((val / pow10(k)) % 10));
    endfunction

    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [SCORE_W-1:0] shadow1;
    logic [SCORE_W-1:0] shadow2;
    logic               tick;
    logic               is_p2;
    logic               blank_all;
    logic [6:0]         pat1 [DIGS];
    logic [6:0]         pat2 [DIGS];
    logic [6:0]         pat_cur;

    assign tick  = (cnt == CNT_W'(DIV - 1));
    assign frame = tick && (idx == IDX_W'(NDIG - 1));
    assign is_p2 = (idx >= IDX_W'(DIGS));

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + 1'b1;
        end
    end

    // NOTE: the shadow scores are ordinary registers, not a memory. Clearing
    // them on reset makes the first frame after reset show "0  0".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow1 <= '0;
            shadow2 <= '0;
        end else if (frame) begin
            shadow1 <= score1;
            shadow2 <= score2;
        end
    end

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path can leave it unassigned and infer a latch.
    always_comb begin
        pat_cur = SEG_BLANK;
        for (int k = 0; k < DIGS; k++) begin
            pat1[k] = digit_pat(shadow1, k);
            pat2[k] = digit_pat(shadow2, k);
            if (idx == IDX_W'(k))        pat_cur = pat1[k];
            if (idx == IDX_W'(k + DIGS)) pat_cur = pat2[k];
        end
    end

`ifdef SCORE_BLINK_EN
    // The blink phase toggles every CLK_HZ/2 clocks, counted in scan ticks.
    localparam int BLINK_TICKS = ((CLK_HZ / 2) / DIV > 0) ? (CLK_HZ / 2) / DIV : 1;
    localparam int BW          = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank_all = blink_off && (is_p2 ? blink[1] : blink[0]);
`else
    logic unused_blink;
    assign unused_blink = ^{blink, is_p2};
    assign blank_all    = 1'b0;
`endif

    // seg/sel are loaded from the index register and the shadow scores, so
    // they trail an index change by one clock and always move together. The
    // one-cycle lag lets a freshly latched shadow drive digit 0 of its frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel <= '1;
            seg <= SEG_BLANK;
        end else begin
            sel <= ~(NDIG'(1) << idx);
            seg <= blank_all ? SEG_BLANK : pat_cur;
        end
    end

endmodule

// File: tb/tb_score_disp_mux.sv
// ---------------------------------------------------------------------------
// tb_score_disp_mux
//   Scoreboard bench for score_disp_mux at CLK_HZ=100, SCAN_HZ=10 (10 clocks
//   per digit, 40 clocks per frame), SCORE_W=7, DIGS=2. The driver changes
//   the scores at random times and, at every frame boundary, pushes the four
//   digits the model expects for the scores present at that boundary. The
//   monitor pops one entry each time sel moves to a new digit. It also checks
//   the one-hot select and the frame pulse position on every clock.
// ---------------------------------------------------------------------------
module tb_score_disp_mux;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] score1 = '0;
    logic [6:0] score2 = '0;
    logic [1:0] blink = 2'b00;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       frame;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    int   cur1 = 0;
    int   cur2 = 0;
    int   plan_idx = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    int plan1 [7] = '{5, 0, 3, 7, 10, 99, 1};
    int plan2 [7] = '{12, 0, 120, 9, 100, 127, 10};

    score_disp_mux #(
        .CLK_HZ (100),
        .SCAN_HZ(10),
        .SCORE_W(7),
        .DIGS   (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .score1(score1),
        .score2(score2),
        .blink (blink),
        .seg   (seg),
        .sel   (sel),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: the score shown as decimal text, capped at 99; positions
    // beyond the text length are blank.
    function automatic logic [6:0] model_seg(input int v, input int pos);
        int    shown;
        string s;
        int    dig;
        shown = (v > 99) ? 99 : v;
        s     = $sformatf("%0d", shown);
        if (pos >= s.len()) return 7'h7F;
        dig = int'(s[s.len() - 1 - pos]) - 48;
        return seg_tab[dig];
    endfunction

    task automatic push_frame(input int v1, input int v2);
        for (int d = 0; d < 4; d++) begin
            exp_t e;
            e.sel = ~(4'b0001 << d);
            e.seg = model_seg((d < 2) ? v1 : v2, d % 2);
            q.push_back(e);
        end
    endtask

    function automatic int pick_score();
        int c;
        int b [4];
        b = '{9, 10, 99, 100};
        c = int'($urandom_range(0, 5));
        if (c == 0) return 0;
        if (c == 1) return int'($urandom_range(1, 9));
        if (c == 2) return int'($urandom_range(10, 99));
        if (c == 3) return int'($urandom_range(100, 127));
        if (c == 4) return b[$urandom_range(0, 3)];
        return int'($urandom_range(0, 127));
    endfunction

    // Run nf frames from a reset release. Entry point is between edges just
    // after release; returns at the falling edge that follows edge 40*nf.
    task automatic run_frames(input int nf);
        for (int n = 1; n <= 40 * nf; n++) begin
            int ph;
            @(posedge clk);
            if (n % 40 == 0 && n < 40 * nf) push_frame(cur1, cur2);
            @(negedge clk);
            ph = n % 40;
            if (ph >= 1 && ph <= 24) begin
                // Mid-frame disturbances: overwritten before the next latch.
                if ($urandom_range(0, 7) == 0) begin cur1 = pick_score(); score1 = 7'(cur1); end
                if ($urandom_range(0, 7) == 0) begin cur2 = pick_score(); score2 = 7'(cur2); end
            end else if (ph == 25) begin
                // Value for the next frame, applied while digit 2 is showing.
                if (plan_idx < 7) begin
                    cur1 = plan1[plan_idx];
                    cur2 = plan2[plan_idx];
                end else begin
                    cur1 = pick_score();
                    cur2 = pick_score();
                end
                plan_idx++;
                score1 = 7'(cur1);
                score2 = 7'(cur2);
            end
        end
    endtask

    // Monitor: owns the cycle count since reset release.
    initial begin
        logic [3:0] prev_sel;
        int         cyc;
        exp_t       e;
        prev_sel = '1;
        cyc      = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_sel = '1;
                cyc      = 0;
            end else begin
                cyc++;
                check("sel_one_hot", 32'($countones(~sel)), 32'd1);
                check("frame_pulse", 32'(frame), 32'((cyc % 40) == 39));
                if (sel !== prev_sel) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL digit_unexpected: got sel=%b seg=%b, expected no new digit (t=%0t)",
                                 sel, seg, $time);
                    end else begin
                        e = q.pop_front();
                        check("digit_sel", 32'(sel), 32'(e.sel));
                        check("digit_seg", 32'(seg), 32'(e.seg));
                    end
                    prev_sel = sel;
                end
            end
        end
    end

    initial begin
        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", 32'(sel), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_frame", 32'(frame), 32'd0);

        @(negedge clk);
        #2;
        push_frame(0, 0);
        rst    = 1'b1;
        mon_en = 1'b1;
        run_frames(12);
        #1;
        check("drain_main", 32'(q.size()), 32'd0);

        // Reset in the middle of the next frame's scan.
        push_frame(cur1, cur2);
        repeat (25) @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("async_reset_sel", 32'(sel), 32'hF);
        check("async_reset_seg", 32'(seg), 32'h7F);
        check("async_reset_frame", 32'(frame), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_reset_sel", 32'(sel), 32'hF);
        check("hold_reset_seg", 32'(seg), 32'h7F);

        @(negedge clk);
        #2;
        q.delete();
        push_frame(0, 0);
        rst    = 1'b1;
        mon_en = 1'b1;
        run_frames(3);
        #1;
        check("drain_restart", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
